uart_key_mapper: RTL and testbench

//  Converts received UART bytes into held paddle-button levels for pong_top and pong_graph.

---
 rtl/uart_key_mapper_if.sv | 28 ++
 rtl/uart_key_mapper.sv | 117 +++++++++++
 tb/tb_uart_key_mapper.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_key_mapper_if.sv
// Byte-in / button-out bundle between uart_rx and the paddle logic.
// master side drives the received byte, slave side (the mapper) drives the decoded outputs.
interface uart_key_mapper_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [3:0] btn;
  logic       start;
  logic [7:0] last_byte;
  logic [7:0] err_cnt;

  modport master (
    output rx_done,
    output rx_data,
    input  btn,
    input  start,
    input  last_byte,
    input  err_cnt
  );

  modport slave (
    input  rx_done,
    input  rx_data,
    output btn,
    output start,
    output last_byte,
    output err_cnt
  );
endinterface

// File: rtl/uart_key_mapper.sv
// Turns UART key bytes into held paddle-button levels plus a one-cycle start pulse.
// Latency: one clk edge from the rx_done rising edge; no backpressure, every rising edge is consumed.
module uart_key_mapper #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic               clk,
  input  logic               reset,
  uart_key_mapper_if.slave   bus
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } pad_state_t;

  pad_state_t       state_q [2];
  pad_state_t       state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];

  logic       rx_prev;
  logic       new_byte;
  logic [1:0] up_key;
  logic [1:0] dn_key;
  logic       is_space;
  logic       mapped;
  logic       start_q;
  logic [7:0] last_q;
  logic [7:0] err_q;
  logic [3:0] btn_c;

  // Byte decode, qualified by the rx_done rising edge.
  always_comb begin
    new_byte = bus.rx_done & ~rx_prev;
    up_key   = 2'b00;
    dn_key   = 2'b00;
    is_space = 1'b0;
    case (bus.rx_data)
      8'h71, 8'h51: up_key[0] = 1'b1;
      8'h61, 8'h41: dn_key[0] = 1'b1;
      8'h6F, 8'h4F: up_key[1] = 1'b1;
      8'h6B, 8'h4B: dn_key[1] = 1'b1;
      8'h20:        is_space  = 1'b1;
      default:      ;
    endcase
    if (!new_byte) begin
      up_key   = 2'b00;
      dn_key   = 2'b00;
      is_space = 1'b0;
    end
    mapped = |{up_key, dn_key, is_space};
  end

  // Paddle next-state: a key always reloads, so reload beats expiry.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      if (up_key[p]) begin
        state_d[p] = UP;
        cnt_d[p]   = RELOAD;
      end else if (dn_key[p]) begin
        state_d[p] = DN;
        cnt_d[p]   = RELOAD;
      end else if (state_q[p] != IDLE) begin
        if (cnt_q[p] == '0) begin
          state_d[p] = IDLE;
        end else begin
          cnt_d[p] = cnt_q[p] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_prev <= 1'b1;
      start_q <= 1'b0;
      last_q  <= 8'h00;
      err_q   <= 8'h00;
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= IDLE;
        cnt_q[p]   <= '0;
      end
    end else begin
      rx_prev <= bus.rx_done;
      start_q <= mapped;
      if (new_byte) begin
        last_q <= bus.rx_data;
      end
      if (new_byte && !mapped && err_q != 8'hFF) begin
        err_q <= err_q + 8'd1;
      end
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
    end
  end

  always_comb begin
    btn_c[0] = (state_q[0] == UP);
    btn_c[1] = (state_q[0] == DN);
    btn_c[2] = (state_q[1] == UP);
    btn_c[3] = (state_q[1] == DN);
  end

  assign bus.btn       = btn_c;
  assign bus.start     = start_q;
  assign bus.last_byte = last_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_uart_key_mapper.sv
// Self-checking bench for uart_key_mapper: directed key scenarios plus random byte traffic,
// compared every cycle against a time-since-last-key model of each paddle.
module tb_uart_key_mapper;

  localparam int H = 8;

  logic clk;
  logic reset;
  uart_key_mapper_if bus ();

  uart_key_mapper #(.HOLD_CYCLES(H), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Model state: per paddle the direction of its last key and cycles elapsed since it.
  bit       m_prev;
  bit [7:0] m_last;
  int       m_err;
  bit       m_start;
  bit       m_dir [2];
  int       m_age [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_btn();
    logic [3:0] b;
    b = 4'b0000;
    for (int p = 0; p < 2; p++)
      if (m_age[p] < H) b[2*p + int'(m_dir[p])] = 1'b1;
    return b;
  endfunction

  task automatic model_key(input int p, input bit d);
    m_dir[p] = d;
    m_age[p] = 0;
    m_start  = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_prev  = 1'b1;
        m_last  = 8'h00;
        m_err   = 0;
        m_start = 1'b0;
        for (int p = 0; p < 2; p++) begin
          m_age[p] = H;
          m_dir[p] = 1'b0;
        end
      end else begin
        bit nb;
        nb      = bus.rx_done && !m_prev;
        m_prev  = bus.rx_done;
        m_start = 1'b0;
        for (int p = 0; p < 2; p++)
          if (m_age[p] < H) m_age[p]++;
        if (nb) begin
          m_last = bus.rx_data;
          case (bus.rx_data)
            8'h71, 8'h51: model_key(0, 1'b0);
            8'h61, 8'h41: model_key(0, 1'b1);
            8'h6F, 8'h4F: model_key(1, 1'b0);
            8'h6B, 8'h4B: model_key(1, 1'b1);
            8'h20:        m_start = 1'b1;
            default:      if (m_err < 255) m_err++;
          endcase
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("btn",       32'(bus.btn),       32'(exp_btn()));
        chk("start",     32'(bus.start),     32'(m_start));
        chk("last_byte", 32'(bus.last_byte), 32'(m_last));
        chk("err_cnt",   32'(bus.err_cnt),   32'(m_err));
      end
    end
  end

  task automatic send(input logic [7:0] b, input int hi, input int lo);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    repeat (hi) @(negedge clk);
    bus.rx_done = 1'b0;
    bus.rx_data = 8'($urandom);
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    int hi_cnt;
    int st_cnt;
    logic [7:0] keys [10];
    keys = '{8'h71, 8'h51, 8'h61, 8'h41, 8'h6F, 8'h4F, 8'h6B, 8'h4B, 8'h20, 8'h7A};

    reset       = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_btn", 32'(bus.btn), 32'h0);
    chk("reset_err", 32'(bus.err_cnt), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Single 'q': exactly H cycles of btn=0001 and one start pulse.
    hi_cnt = 0;
    st_cnt = 0;
    bus.rx_data = 8'h71;
    bus.rx_done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus.rx_done = 1'b0;
      if (bus.btn == 4'b0001) hi_cnt++;
      if (bus.start) st_cnt++;
    end
    chk("q_hold_cycles", 32'(hi_cnt), 32'd8);
    chk("q_start_pulses", 32'(st_cnt), 32'd1);
    chk("q_last_byte", 32'(bus.last_byte), 32'h71);

    // 'A' then 'k' three cycles later: both paddles held at once.
    send(8'h41, 1, 2);
    send(8'h6B, 1, 1);
    chk("ak_btn", 32'(bus.btn), 32'b1010);
    repeat (12) @(negedge clk);
    chk("ak_expired", 32'(bus.btn), 32'h0);

    // Auto-repeat 'o' every 5 cycles keeps P2 up without gaps.
    repeat (4) send(8'h6F, 2, 3);
    chk("o_repeat_btn", 32'(bus.btn), 32'b0100);
    repeat (12) @(negedge clk);
    chk("o_expired", 32'(bus.btn), 32'h0);

    // Direction switch 'q' -> 'a' four cycles apart.
    send(8'h71, 1, 3);
    send(8'h61, 1, 0);
    chk("qa_switch_btn", 32'(bus.btn), 32'b0010);
    repeat (12) @(negedge clk);

    // Unmapped bytes saturate the error counter.
    repeat (300) send(8'h7A, 1, 1);
    chk("err_saturated", 32'(bus.err_cnt), 32'hFF);
    chk("z_btn", 32'(bus.btn), 32'h0);

    // Reset mid-hold, with rx_done raised during reset and held across release.
    send(8'h71, 1, 2);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_drops_btn", 32'(bus.btn), 32'h0);
    bus.rx_data = 8'h71;
    bus.rx_done = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    st_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.start) st_cnt++;
    end
    chk("held_no_start", 32'(st_cnt), 32'd0);
    bus.rx_done = 1'b0;
    @(negedge clk);

    // Random traffic over mapped, space and arbitrary bytes.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] b;
      if ($urandom_range(0, 3) == 0) b = 8'($urandom);
      else b = keys[$urandom_range(0, 9)];
      send(b, $urandom_range(1, 3), $urandom_range(1, 10));
    end
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
